// File: rtl/adc_multi_ch_capture.sv
`default_nettype none
// =============================================================================
// adc_multi_ch_capture: N-channel CNV/BUSY/SPI capture into a ping-pong DPBRAM
// with a per-channel moving sum. `ADC_SUM_AVERAGE_EN selects average output.
// Revision: 1.0
// =============================================================================
module adc_multi_ch_capture #(
  parameter int CH_NUM     = 2,
  parameter int DWIDTH     = 24,
  parameter int RAM_DEPTH  = 20000,
  parameter int SUM_LOG2   = 4,
  parameter int CNV_PERIOD = 200,
  parameter int CNV_HIGH   = 20,
  parameter int TIMEOUT    = 400
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  input  logic                           i_en,
  input  logic [CH_NUM-1:0]              i_busy,
  output logic                           o_cnv,
  output logic                           o_spi_start,
  input  logic [CH_NUM-1:0]              i_data_valid,
  input  logic [CH_NUM*DWIDTH-1:0]       i_miso_data,
  output logic [$clog2(RAM_DEPTH)-1:0]   o_ram_addr,
  output logic                           o_ram_ce,
  output logic                           o_ram_we,
  output logic [CH_NUM*DWIDTH-1:0]       o_ram_dout,
  input  logic [1:0]                     i_flag_clr,
  output logic                           o_half1_flag,
  output logic                           o_half2_flag,
  output logic                           o_overrun,
  output logic                           o_timeout,
  output logic [CH_NUM*32-1:0]           o_sum_data,
  output logic                           o_sum_valid,
  output logic [2:0]                     o_state
);

  localparam int c_AW   = $clog2(RAM_DEPTH);
  localparam int c_SW   = DWIDTH + SUM_LOG2;
  localparam int c_HD   = 1 << SUM_LOG2;
  localparam int c_HALF = RAM_DEPTH / 2;
  localparam int c_PMAX = CNV_PERIOD + CNV_HIGH + 2 * TIMEOUT + 4;
  localparam int c_PW   = $clog2(c_PMAX + 1);
  localparam int c_TW   = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CNV   = 3'd1,
    S_BUSY  = 3'd2,
    S_SPI   = 3'd3,
    S_STORE = 3'd4,
    S_WAIT  = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic                w_timeout_hit;
  logic [CH_NUM-1:0]   w_seen;
  logic [CH_NUM-1:0]   r_seen;
  logic [c_PW-1:0]     r_pcnt;
  logic [c_TW-1:0]     r_tcnt;
  logic                r_spi_start;
  logic [c_AW-1:0]     r_addr;
  logic                r_half1;
  logic                r_half2;
  logic                r_overrun;
  logic                r_timeout;
  logic                r_sum_valid;
  logic [SUM_LOG2-1:0] r_hptr;
  logic                w_store;
  logic                w_set1;
  logic                w_set2;

  always_comb begin
    w_next        = r_state;
    w_timeout_hit = 1'b0;
    w_seen        = r_seen | i_data_valid;
    case (r_state)
      S_IDLE:  if (i_en) w_next = S_CNV;
      S_CNV:   if (r_pcnt == c_PW'(CNV_HIGH - 1)) w_next = S_BUSY;
      S_BUSY: begin
        if (i_busy == '0) begin
          w_next = S_SPI;
        end else if (r_tcnt == c_TW'(TIMEOUT - 1)) begin
          w_next        = S_WAIT;
          w_timeout_hit = 1'b1;
        end
      end
      S_SPI: begin
        if (&w_seen) begin
          w_next = S_STORE;
        end else if (r_tcnt == c_TW'(TIMEOUT - 1)) begin
          w_next        = S_WAIT;
          w_timeout_hit = 1'b1;
        end
      end
      S_STORE: w_next = S_WAIT;
      // >= rather than == so an overlong (timed-out) sample still resumes
      S_WAIT:  if (r_pcnt >= c_PW'(CNV_PERIOD - 1)) w_next = i_en ? S_CNV : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  assign w_store = (r_state == S_STORE);
  assign w_set1  = w_store && (r_addr == c_AW'(c_HALF - 1));
  assign w_set2  = w_store && (r_addr == c_AW'(RAM_DEPTH - 1));

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_pcnt      <= '0;
      r_tcnt      <= '0;
      r_seen      <= '0;
      r_spi_start <= 1'b0;
      r_addr      <= '0;
      r_half1     <= 1'b0;
      r_half2     <= 1'b0;
      r_overrun   <= 1'b0;
      r_timeout   <= 1'b0;
      r_sum_valid <= 1'b0;
      r_hptr      <= '0;
    end else begin
      r_state     <= w_next;
      r_spi_start <= (r_state == S_BUSY) && (w_next == S_SPI);
      r_sum_valid <= w_store;

      if (w_next == S_CNV && r_state != S_CNV) begin
        r_pcnt <= '0;
      end else if (r_state != S_IDLE && r_pcnt != c_PW'(c_PMAX)) begin
        r_pcnt <= r_pcnt + 1'b1;
      end

      if (w_next != r_state || !(r_state == S_BUSY || r_state == S_SPI)) begin
        r_tcnt <= '0;
      end else begin
        r_tcnt <= r_tcnt + 1'b1;
      end

      r_seen <= (r_state == S_SPI) ? w_seen : '0;

      if (w_timeout_hit) r_timeout <= 1'b1;

      if (w_store) begin
        r_hptr <= r_hptr + 1'b1;
        r_addr <= w_set2 ? '0 : r_addr + 1'b1;
        if ((r_addr == '0 && r_half1) || (r_addr == c_AW'(c_HALF) && r_half2)) begin
          r_overrun <= 1'b1;
        end
      end

      if (w_set1) r_half1 <= 1'b1;
      else if (i_flag_clr[0]) r_half1 <= 1'b0;
      if (w_set2) r_half2 <= 1'b1;
      else if (i_flag_clr[1]) r_half2 <= 1'b0;
    end
  end

  for (genvar k = 0; k < CH_NUM; k++) begin : g_ch
    logic [DWIDTH-1:0]      r_cap;
    logic [DWIDTH-1:0]      r_hist [c_HD];
    logic signed [c_SW-1:0] r_sum;
    logic signed [31:0]     r_out;
    logic signed [c_SW-1:0] w_new;
    logic signed [c_SW-1:0] w_old;
    logic signed [c_SW-1:0] w_sum;
    logic signed [c_SW-1:0] w_res;

    always_comb begin
      w_new = c_SW'($signed(r_cap));
      w_old = c_SW'($signed(r_hist[r_hptr]));
      w_sum = r_sum + w_new - w_old;
`ifdef ADC_SUM_AVERAGE_EN
      w_res = w_sum >>> SUM_LOG2;
`else
      w_res = w_sum;
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        r_cap <= '0;
        r_sum <= '0;
        r_out <= '0;
        for (int i = 0; i < c_HD; i++) r_hist[i] <= '0;
      end else begin
        if (r_state == S_SPI && i_data_valid[k]) begin
          r_cap <= i_miso_data[k*DWIDTH +: DWIDTH];
        end
        // history starts zeroed, so the first window subtracts nothing
        if (w_store) begin
          r_hist[r_hptr] <= r_cap;
          r_sum          <= w_sum;
          r_out          <= 32'(w_res);
        end
      end
    end

    assign o_ram_dout[k*DWIDTH +: DWIDTH] = r_cap;
    assign o_sum_data[k*32 +: 32]         = r_out;
  end

  assign o_cnv        = (r_state == S_CNV);
  assign o_spi_start  = r_spi_start;
  assign o_ram_addr   = r_addr;
  assign o_ram_ce     = w_store;
  assign o_ram_we     = 1'b1;
  assign o_half1_flag = r_half1;
  assign o_half2_flag = r_half2;
  assign o_overrun    = r_overrun;
  assign o_timeout    = r_timeout;
  assign o_sum_valid  = r_sum_valid;
  assign o_state      = r_state;

endmodule
`default_nettype wire
